can_frame_classifier: RTL and testbench
=======================================

Name: can_frame_classifier

Overview:
Clocked, parametrised frame classifier for the CAN/CAN FD decoder. Consumes destuffed bits one per sample point, walks the arbitration and control fields, and reports:
- frame type (classic data, classic remote, FD data, rejected)
- IDE and the full identifier, with a one-cycle valid strobe
- saturating per-type frame counters

Sits between the bit destuffer and the DLC/data-field decoder.

Parameters:
FD_ENABLE, 1, 1: FDF=1 frames are classified as FD data; 0: FDF=1 frames are classified as rejected (type 3).
COUNT_W, 16, width of each saturating frame counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
sof  in  1  one-cycle strobe; the next bit_valid carries ID[10] (or ID-A[10])
bit_valid  in  1  one-cycle strobe at sample point, stuff bits already removed
rx_bit  in  1  destuffed bit value, qualified by bit_valid
abort  in  1  one-cycle strobe from error/bus-off logic; cancels the frame in progress
clr_cnt  in  1  synchronous clear of all counters
type_valid  out  1  one-cycle strobe; classification outputs are valid
type_fr  out  2  0 classic data, 1 classic remote, 2 FD data, 3 rejected
ide  out  1  1 = extended identifier
id  out  29  identifier; base frames right-aligned in [10:0], upper bits zero
busy  out  1  classification in progress (state != IDLE)
cnt_data  out  COUNT_W  classic data frames seen
cnt_remote  out  COUNT_W  classic remote frames seen
cnt_fd  out  COUNT_W  FD data frames seen

Behaviour:
- Reset (async, active-high): state=IDLE, bit counter=0.
  - All outputs 0: type_valid, type_fr, ide, id, busy, all counters.
- FSM states: IDLE, BASE_ID, RTR_SRR, IDE, EXT_ID, RTR_RRS, FDF, DONE.
  - Every transition except IDLE->BASE_ID and DONE->IDLE consumes exactly one bit_valid.
- IDLE: sof -> BASE_ID, bit counter loaded with 10. bit_valid alone is ignored.
- BASE_ID: shift rx_bit into id shadow MSB-first; leave after the 11th bit -> RTR_SRR.
- RTR_SRR: latch bit as rtr_a -> IDE.
- IDE: latch ide.
  - ide=0 -> FDF, with rtr = rtr_a.
  - ide=1 -> EXT_ID, bit counter loaded with 17.
- EXT_ID: shift 18 bits -> RTR_RRS. Extended id = {ID-A[10:0], ID-B[17:0]}.
- RTR_RRS: latch bit as rtr -> FDF.
- FDF (base frames: r0 in classic CAN; extended frames: r1):
  - fdf=0: type = rtr ? 1 : 0.
  - fdf=1 and FD_ENABLE=1: type = 2; the rtr/RRS value is ignored.
  - fdf=1 and FD_ENABLE=0: type = 3.
  - After the FDF bit -> DONE.
- DONE (one clk): type_valid=1; type_fr, ide and id updated in the same cycle; the matching counter increments (type 3 increments none); -> IDLE.
  - Latency: type_valid rises on the first clk edge after the cycle carrying the FDF bit_valid.
- type_fr, ide and id hold their last value between frames. The shadow id register is separate, so outputs do not change mid-frame.
- busy = (state != IDLE), registered.
- Counters saturate at all-ones. clr_cnt takes priority over a same-cycle increment (result 0).
- sof while busy: restart at BASE_ID and discard the partial frame. No type_valid for the discarded frame.
- abort: -> IDLE next clk and no type_valid. abort in DONE suppresses type_valid and the counter increment. abort beats a simultaneous sof.
- sof and bit_valid in the same cycle in IDLE: that bit is the SOF bit and is not consumed.
- bit_valid with sof in a non-IDLE state: the sof restart wins and the bit is dropped.

Decomposition:
- Package can_pkg:
  - frame_type_e enum: TYPE_DATA=0, TYPE_REMOTE=1, TYPE_FD_DATA=2, TYPE_REJECT=3
  - classifier state enum
  - constants BASE_ID_BITS=11, EXT_ID_BITS=18, ID_W=29
- One sub-module: can_sat_counter (COUNT_W, inc, clr, async reset), instantiated three times.

Test Plan:
- Base classic data: sof, bits 0x123 (MSB first), RTR=0, IDE=0, r0=0 -> type_valid one clk after the 14th bit; type_fr=0, ide=0, id=0x123, cnt_data=1.
- Base remote: ID 0x7FF, RTR=1, IDE=0, r0=0 -> type_fr=1, id=0x7FF, cnt_remote=1, cnt_data unchanged.
- Extended FD (FD_ENABLE=1): ID-A 0x155, SRR=1, IDE=1, ID-B 0x2AAAA, RRS=0, FDF=1 -> type_fr=2, ide=1, id=0x556AAAA, cnt_fd=1.
- FD_ENABLE=0: base ID 0x010, RTR=0, IDE=0, FDF=1 -> type_fr=3, type_valid=1, no counter changes.
- abort after the 5th EXT_ID bit -> busy=0 next clk, no type_valid. A following base data frame with ID 0x001 classifies correctly (type 0, id 0x001).
- COUNT_W=2: five classic data frames -> cnt_data=3.
  - Then clr_cnt coincident with a sixth frame's DONE -> cnt_data=0.
  - Reset asserted mid-BASE_ID -> all outputs 0 immediately.

Source files
------------

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN frame classifier.
package can_pkg;

    localparam int unsigned BASE_ID_BITS = 11;
    localparam int unsigned EXT_ID_BITS  = 18;
    localparam int unsigned ID_W         = 29;

    typedef enum logic [1:0] {
        TYPE_DATA    = 2'd0,
        TYPE_REMOTE  = 2'd1,
        TYPE_FD_DATA = 2'd2,
        TYPE_REJECT  = 2'd3
    } frame_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BASE_ID,
        ST_RTR_SRR,
        ST_IDE,
        ST_EXT_ID,
        ST_RTR_RRS,
        ST_FDF,
        ST_DONE
    } cls_state_e;

    // With FDF set the RTR/RRS position carries no remote request, so it is ignored.
    function automatic frame_type_e classify(input logic fdf, input logic rtr, input logic fd_en);
        if (!fdf)
            return rtr ? TYPE_REMOTE : TYPE_DATA;
        else if (fd_en)
            return TYPE_FD_DATA;
        else
            return TYPE_REJECT;
    endfunction

endpackage

// File: rtl/can_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module can_sat_counter #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/can_frame_classifier.sv
// Walks CAN/CAN FD arbitration and control fields on destuffed bits and
// classifies each frame, keeping saturating per-type frame counters.
module can_frame_classifier
    import can_pkg::*;
#(
    parameter bit          FD_ENABLE = 1'b1,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sof,
    input  logic               bit_valid,
    input  logic               rx_bit,
    input  logic               abort,
    input  logic               clr_cnt,
    output logic               type_valid,
    output logic [1:0]         type_fr,
    output logic               ide,
    output logic [ID_W-1:0]    id,
    output logic               busy,
    output logic [COUNT_W-1:0] cnt_data,
    output logic [COUNT_W-1:0] cnt_remote,
    output logic [COUNT_W-1:0] cnt_fd
);

    cls_state_e      state, state_n;
    logic [4:0]      bit_cnt, bit_cnt_n;
    logic [ID_W-1:0] id_sh, id_sh_n;
    logic            rtr_a, rtr_a_n;
    logic            ide_sh, ide_sh_n;
    logic            rtr_sh, rtr_sh_n;
    logic            load_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            id_sh   <= '0;
            rtr_a   <= 1'b0;
            ide_sh  <= 1'b0;
            rtr_sh  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            id_sh   <= id_sh_n;
            rtr_a   <= rtr_a_n;
            ide_sh  <= ide_sh_n;
            rtr_sh  <= rtr_sh_n;
            busy    <= (state_n != ST_IDLE);
        end
    end

    // Priority: abort, then sof restart, then normal field walk.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        id_sh_n   = id_sh;
        rtr_a_n   = rtr_a;
        ide_sh_n  = ide_sh;
        rtr_sh_n  = rtr_sh;
        if (abort) begin
            state_n = ST_IDLE;
        end else if (sof) begin
            state_n   = ST_BASE_ID;
            bit_cnt_n = 5'(BASE_ID_BITS - 1);
            id_sh_n   = '0;
        end else begin
            case (state)
                ST_BASE_ID, ST_EXT_ID: begin
                    if (bit_valid) begin
                        id_sh_n = {id_sh[ID_W-2:0], rx_bit};
                        if (bit_cnt == 5'd0)
                            state_n = (state == ST_BASE_ID) ? ST_RTR_SRR : ST_RTR_RRS;
                        else
                            bit_cnt_n = bit_cnt - 5'd1;
                    end
                end
                ST_RTR_SRR: begin
                    if (bit_valid) begin
                        rtr_a_n = rx_bit;
                        state_n = ST_IDE;
                    end
                end
                ST_IDE: begin
                    if (bit_valid) begin
                        ide_sh_n = rx_bit;
                        if (rx_bit) begin
                            state_n   = ST_EXT_ID;
                            bit_cnt_n = 5'(EXT_ID_BITS - 1);
                        end else begin
                            rtr_sh_n = rtr_a;
                            state_n  = ST_FDF;
                        end
                    end
                end
                ST_RTR_RRS: begin
                    if (bit_valid) begin
                        rtr_sh_n = rx_bit;
                        state_n  = ST_FDF;
                    end
                end
                ST_FDF: begin
                    if (bit_valid)
                        state_n = ST_DONE;
                end
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign load_out = (state == ST_FDF) && (state_n == ST_DONE);

    // Visible outputs only change when a frame completes, so they are stable during DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_fr <= '0;
            ide     <= 1'b0;
            id      <= '0;
        end else if (load_out) begin
            type_fr <= classify(rx_bit, rtr_sh, FD_ENABLE);
            ide     <= ide_sh;
            id      <= id_sh;
        end
    end

    always_comb begin
        type_valid = (state == ST_DONE) && !abort;
    end

    can_sat_counter #(.COUNT_W(COUNT_W)) u_cnt_data (
        .clk   (clk),
        .reset (reset),
        .inc   (type_valid && (type_fr == TYPE_DATA)),
        .clr   (clr_cnt),
        .count (cnt_data)
    );

    can_sat_counter #(.COUNT_W(COUNT_W)) u_cnt_remote (
        .clk   (clk),
        .reset (reset),
        .inc   (type_valid && (type_fr == TYPE_REMOTE)),
        .clr   (clr_cnt),
        .count (cnt_remote)
    );

    can_sat_counter #(.COUNT_W(COUNT_W)) u_cnt_fd (
        .clk   (clk),
        .reset (reset),
        .inc   (type_valid && (type_fr == TYPE_FD_DATA)),
        .clr   (clr_cnt),
        .count (cnt_fd)
    );

endmodule

// File: tb/tb_can_frame_classifier.sv
// Directed bench: three classifier instances (FD on, FD off, 2-bit counters) share stimulus.
module tb_can_frame_classifier;

    logic clk = 1'b0;
    logic reset, sof, bit_valid, rx_bit, abort, clr_cnt;

    logic        tv_a, ide_a, busy_a;
    logic [1:0]  ty_a;
    logic [28:0] id_a;
    logic [15:0] cd_a, cr_a, cf_a;

    logic        tv_b, ide_b, busy_b;
    logic [1:0]  ty_b;
    logic [28:0] id_b;
    logic [15:0] cd_b, cr_b, cf_b;

    logic        tv_c, ide_c, busy_c;
    logic [1:0]  ty_c;
    logic [28:0] id_c;
    logic [1:0]  cd_c, cr_c, cf_c;

    int tests = 0;
    int failed = 0;
    int tv_pulses = 0;
    int snap;

    always #5 clk = ~clk;

    can_frame_classifier #(.FD_ENABLE(1'b1), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .sof(sof), .bit_valid(bit_valid), .rx_bit(rx_bit),
        .abort(abort), .clr_cnt(clr_cnt), .type_valid(tv_a), .type_fr(ty_a), .ide(ide_a),
        .id(id_a), .busy(busy_a), .cnt_data(cd_a), .cnt_remote(cr_a), .cnt_fd(cf_a)
    );

    can_frame_classifier #(.FD_ENABLE(1'b0), .COUNT_W(16)) dut_nofd (
        .clk(clk), .reset(reset), .sof(sof), .bit_valid(bit_valid), .rx_bit(rx_bit),
        .abort(abort), .clr_cnt(clr_cnt), .type_valid(tv_b), .type_fr(ty_b), .ide(ide_b),
        .id(id_b), .busy(busy_b), .cnt_data(cd_b), .cnt_remote(cr_b), .cnt_fd(cf_b)
    );

    can_frame_classifier #(.FD_ENABLE(1'b1), .COUNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .sof(sof), .bit_valid(bit_valid), .rx_bit(rx_bit),
        .abort(abort), .clr_cnt(clr_cnt), .type_valid(tv_c), .type_fr(ty_c), .ide(ide_c),
        .id(id_c), .busy(busy_c), .cnt_data(cd_c), .cnt_remote(cr_c), .cnt_fd(cf_c)
    );

    // Counts type_valid pulses of the main instance as held across each active edge.
    always @(posedge clk) begin
        if (tv_a === 1'b1)
            tv_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_sof();
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        rx_bit    = b;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // Leaves the bench at the negedge where DONE is visible.
    task automatic send_body(input logic [10:0] ida, input logic rtr_srr, input logic ide_bit,
                             input logic [17:0] idb, input logic rrs, input logic fdf);
        for (int i = 10; i >= 0; i--) send_bit(ida[i]);
        send_bit(rtr_srr);
        send_bit(ide_bit);
        if (ide_bit) begin
            for (int i = 17; i >= 0; i--) send_bit(idb[i]);
            send_bit(rrs);
        end
        send_bit(fdf);
    endtask

    task automatic send_frame(input logic [10:0] ida, input logic rtr_srr, input logic ide_bit,
                              input logic [17:0] idb, input logic rrs, input logic fdf);
        pulse_sof();
        send_body(ida, rtr_srr, ide_bit, idb, rrs, fdf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; sof = 1'b0; bit_valid = 1'b0; rx_bit = 1'b0; abort = 1'b0; clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst type_valid", {31'd0, tv_a}, 32'd0);
        check("rst busy", {31'd0, busy_a}, 32'd0);
        check("rst id", {3'd0, id_a}, 32'd0);
        check("rst cnt_data", {16'd0, cd_a}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Base classic data, ID 0x123
        send_frame(11'h123, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        check("bd type_valid", {31'd0, tv_a}, 32'd1);
        check("bd busy", {31'd0, busy_a}, 32'd1);
        check("bd type", {30'd0, ty_a}, 32'd0);
        check("bd ide", {31'd0, ide_a}, 32'd0);
        check("bd id", {3'd0, id_a}, 32'h123);
        @(negedge clk);
        check("bd pulse end", {31'd0, tv_a}, 32'd0);
        check("bd idle", {31'd0, busy_a}, 32'd0);
        check("bd cnt_data", {16'd0, cd_a}, 32'd1);

        // Base remote, ID 0x7FF
        send_frame(11'h7FF, 1'b1, 1'b0, 18'h0, 1'b0, 1'b0);
        check("br type", {30'd0, ty_a}, 32'd1);
        check("br id", {3'd0, id_a}, 32'h7FF);
        @(negedge clk);
        check("br cnt_remote", {16'd0, cr_a}, 32'd1);
        check("br cnt_data", {16'd0, cd_a}, 32'd1);

        // Extended FD: ID-A 0x155, SRR=1, ID-B 0x2AAAA, RRS=0, FDF=1
        send_frame(11'h155, 1'b1, 1'b1, 18'h2AAAA, 1'b0, 1'b1);
        check("xfd valid", {31'd0, tv_a}, 32'd1);
        check("xfd type", {30'd0, ty_a}, 32'd2);
        check("xfd ide", {31'd0, ide_a}, 32'd1);
        check("xfd id", {3'd0, id_a}, 32'h556AAAA);
        check("xfd nofd type", {30'd0, ty_b}, 32'd3);
        @(negedge clk);
        check("xfd cnt_fd", {16'd0, cf_a}, 32'd1);
        check("xfd nofd cnt_fd", {16'd0, cf_b}, 32'd0);

        // FDF=1 base 0x010 on the FD-disabled instance
        send_frame(11'h010, 1'b0, 1'b0, 18'h0, 1'b0, 1'b1);
        check("rej valid", {31'd0, tv_b}, 32'd1);
        check("rej type", {30'd0, ty_b}, 32'd3);
        check("rej id", {3'd0, id_b}, 32'h010);
        @(negedge clk);
        check("rej cnt_data", {16'd0, cd_b}, 32'd1);
        check("rej cnt_remote", {16'd0, cr_b}, 32'd1);
        check("rej cnt_fd", {16'd0, cf_b}, 32'd0);
        check("fd2 cnt_fd", {16'd0, cf_a}, 32'd2);

        // Abort after the 5th EXT_ID bit
        snap = tv_pulses;
        pulse_sof();
        for (int i = 10; i >= 0; i--) send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("ab id hold", {3'd0, id_a}, 32'h010);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab busy", {31'd0, busy_a}, 32'd0);
        check("ab no pulse", tv_pulses - snap, 32'd0);
        send_frame(11'h001, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        check("ab next type", {30'd0, ty_a}, 32'd0);
        check("ab next id", {3'd0, id_a}, 32'h001);
        @(negedge clk);
        check("ab one pulse", tv_pulses - snap, 32'd1);

        // Three more data frames: 5 total on the 2-bit counter
        for (int f = 0; f < 3; f++) begin
            send_frame(11'h0A5, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
            @(negedge clk);
        end
        check("sat cnt_data", {30'd0, cd_c}, 32'd3);
        check("wide cnt_data", {16'd0, cd_a}, 32'd5);

        // clr_cnt coincident with DONE of a sixth frame
        send_frame(11'h0A5, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        check("clr valid", {31'd0, tv_c}, 32'd1);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("clr cnt_data", {30'd0, cd_c}, 32'd0);
        check("clr cnt_fd", {16'd0, cf_a}, 32'd0);

        // sof with bit_valid in IDLE: that bit is not an ID bit
        @(negedge clk);
        sof = 1'b1; bit_valid = 1'b1; rx_bit = 1'b1;
        @(negedge clk);
        sof = 1'b0; bit_valid = 1'b0;
        send_body(11'h0F0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        check("sofbv id", {3'd0, id_a}, 32'h0F0);
        @(negedge clk);

        // Restart mid-frame with sof+bit_valid: bit dropped, partial frame discarded
        snap = tv_pulses;
        pulse_sof();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk);
        sof = 1'b1; bit_valid = 1'b1; rx_bit = 1'b1;
        @(negedge clk);
        sof = 1'b0; bit_valid = 1'b0;
        send_body(11'h2A5, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        check("rs type", {30'd0, ty_a}, 32'd0);
        check("rs id", {3'd0, id_a}, 32'h2A5);
        @(negedge clk);
        check("rs one pulse", tv_pulses - snap, 32'd1);
        check("rs cnt_data", {16'd0, cd_a}, 32'd2);

        // abort during DONE suppresses pulse and counter
        snap = tv_pulses;
        send_frame(11'h3C3, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0);
        abort = 1'b1;
        #1;
        check("abd no valid", {31'd0, tv_a}, 32'd0);
        @(negedge clk);
        abort = 1'b0;
        check("abd no pulse", tv_pulses - snap, 32'd0);
        check("abd cnt_data", {16'd0, cd_a}, 32'd2);

        // Asynchronous reset in the middle of BASE_ID
        pulse_sof();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst busy", {31'd0, busy_a}, 32'd0);
        check("arst id", {3'd0, id_a}, 32'd0);
        check("arst type", {30'd0, ty_a}, 32'd0);
        check("arst cnt_data", {16'd0, cd_a}, 32'd0);
        check("arst cnt_remote", {16'd0, cr_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
